// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for the instruction memory.
// Holds the CPU in reset while it loads and verifies the XOR checksum.
module imem_loader #(
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA,
    S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t            state_q;
  logic [7:0]        len_hi_q;
  logic [15:0]       len_q;
  logic [31:0]       word_q;
  logic [1:0]        idx_q;
  logic [7:0]        acc_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              hold_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [ADDR_W:0]   cnt_q;

  logic              xfer;
  logic [15:0]       len_d;
  logic [31:0]       word_d;
  logic [ADDR_W:0]   cnt_d;

  // Ready is a pure decode of the registered state.
  assign byte_ready = (state_q == S_LEN_HI) | (state_q == S_LEN_LO) |
                      (state_q == S_DATA)   | (state_q == S_CHECK);
  assign xfer   = byte_valid & byte_ready;
  assign len_d  = {len_hi_q, byte_data};
  assign word_d = {word_q[23:0], byte_data};
  assign cnt_d  = cnt_q + 1'b1;

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = cnt_q;

  // Loader FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_hi_q  <= '0;
      len_q     <= '0;
      word_q    <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q <= S_LEN_HI;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            hold_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi_q <= byte_data;
            state_q  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_q <= len_d;
            if (len_d == '0 || {1'b0, len_d} > DEPTH) begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
              idx_q   <= '0;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            word_q <= word_d;
            acc_q  <= acc_q ^ byte_data;
            idx_q  <= idx_q + 1'b1;
            if (idx_q == 2'd3) begin
              state_q   <= S_WRITE;
              wr_en_q   <= 1'b1;
              wr_addr_q <= cnt_q[ADDR_W-1:0];
              wr_data_q <= word_d;
            end
          end
        end
        S_WRITE: begin
          cnt_q   <= cnt_d;
          state_q <= (16'(cnt_d) == len_q) ? S_CHECK : S_DATA;
        end
        S_CHECK: begin
          if (xfer) begin
            busy_q <= 1'b0;
            if (byte_data == acc_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frames checked against a frame-level model.
// Writes are captured by a monitor and compared with the expected image.
module tb_imem_loader;
  localparam int AW = 7;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  imem_loader #(.ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .error(error), .word_count(word_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic [AW+31:0] got[$];
  bit prev_wr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Capture writes; a write is one cycle with ready low, then ready returns.
  always @(negedge clock) begin
    if (prev_wr) begin
      checks++;
      assert (wr_en === 1'b0 && byte_ready === 1'b1) else begin
        failures++;
        $error("FAIL wr_after observed=%b%b expected=01", wr_en, byte_ready);
      end
    end
    if (wr_en === 1'b1) begin
      got.push_back({wr_addr, wr_data});
      checks++;
      assert (byte_ready === 1'b0) else begin
        failures++;
        $error("FAIL wr_ready observed=%b expected=0", byte_ready);
      end
    end
    prev_wr = (wr_en === 1'b1);
  end

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
  endtask

  // mode 0: random valid, mode 1: valid toggles every cycle.
  task automatic send(input logic [7:0] fr[$], input int mode);
    int i = 0;
    int cyc = 0;
    bit tog = 1'b1;
    bit v;
    while (i < fr.size() && cyc < 5000) begin
      @(negedge clock);
      cyc++;
      v = (mode == 1) ? tog : ($urandom_range(0, 2) != 0);
      tog = ~tog;
      start = (i >= 1) && ($urandom_range(0, 7) == 0);
      byte_valid = v;
      byte_data = fr[i];
      if (v && byte_ready === 1'b1) i++;
    end
    @(negedge clock);
    byte_valid = 1'b0;
    start = 1'b0;
    chk("bytes_taken", 64'(i), 64'(fr.size()));
  endtask

  task automatic load(input string tag, input int n,
                      input logic [31:0] w[$], input logic [7:0] cmask,
                      input int mode);
    logic [7:0] fr[$];
    logic [7:0] cs;
    logic [AW+31:0] exp[$];
    logic [31:0] word;
    bit ok;
    bit good;
    fr = {};
    exp = {};
    cs = 8'h00;
    fr.push_back(8'(n >> 8));
    fr.push_back(8'(n));
    ok = (n >= 1) && (n <= (1 << AW));
    if (ok) begin
      for (int k = 0; k < n; k++) begin
        word = w[k];
        for (int b = 3; b >= 0; b--) begin
          fr.push_back(8'(word >> (8 * b)));
          cs ^= 8'(word >> (8 * b));
        end
        exp.push_back({AW'(k), word});
      end
      fr.push_back(cs ^ cmask);
    end
    good = ok && (cmask == 8'h00);
    got.delete();
    do_start();
    send(fr, mode);
    repeat (2) @(negedge clock);
    chk({tag, "_done"}, 64'(done), 64'(good));
    chk({tag, "_error"}, 64'(error), 64'(!good));
    chk({tag, "_hold"}, 64'(cpu_hold), 64'(!good));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_ready"}, 64'(byte_ready), 64'(0));
    chk({tag, "_wcount"}, 64'(word_count), 64'(ok ? n : 0));
    chk({tag, "_nwrites"}, 64'(got.size()), 64'(exp.size()));
    for (int k = 0; k < exp.size() && k < got.size(); k++)
      chk({tag, "_write"}, 64'(got[k]), 64'(exp[k]));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(byte_ready), 64'(0));
    chk({tag, "_wr_en"}, 64'(wr_en), 64'(0));
    chk({tag, "_addr"}, 64'(wr_addr), 64'(0));
    chk({tag, "_data"}, 64'(wr_data), 64'(0));
    chk({tag, "_flags"}, 64'({cpu_hold, busy, done, error}), 64'(0));
    chk({tag, "_wcount"}, 64'(word_count), 64'(0));
  endtask

  initial begin
    logic [31:0] w[$];
    logic [7:0] part[$];
    reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (2) @(negedge clock);
    chk_reset_vals("reset");
    reset = 1'b0;

    w = {32'h12345678};
    load("t1", 1, w, 8'h00, 0);

    w = {32'hDEADBEEF, 32'h00000001, 32'hFFFFFFFF};
    load("t2", 3, w, 8'h00, 1);

    w = {};
    load("t3_len0", 0, w, 8'h00, 0);
    load("t3_len129", 129, w, 8'h00, 0);

    w = {32'h11223344};
    load("t4", 1, w, 8'h44, 0);

    w = {};
    for (int k = 0; k < 128; k++) w.push_back($urandom);
    load("t5", 128, w, 8'h00, 0);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 8);
      w = {};
      for (int k = 0; k < n; k++) w.push_back($urandom);
      load("rand", n, w, (r % 3 == 2) ? 8'($urandom_range(1, 255)) : 8'h00, 0);
    end

    part = {8'h00, 8'h01, 8'h12, 8'h34};
    got.delete();
    do_start();
    send(part, 0);
    chk("t6_busy", 64'({busy, cpu_hold, wr_en}), 64'(3'b110));
    reset = 1'b1;
    start = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h56;
    @(negedge clock);
    chk_reset_vals("t6");
    reset = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    chk("t6_nwrites", 64'(got.size()), 64'(0));

    w = {32'hCAFEF00D, 32'h0BADC0DE};
    load("t6_after", 2, w, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader. It is the write side of the instruction memory the CPU fetches from.
- Accepts a framed byte stream over a valid/ready handshake and assembles 32-bit big-endian words. Writes them to consecutive instruction-memory word addresses starting at 0.
- Holds the CPU in reset (cpu_hold) while loading. Verifies a trailing XOR checksum.
- Sits between the board-level byte source (UART receiver or switch-entry block) and the instruction memory write port. Top level ORs cpu_hold into CPU reset.

Parameters:
ADDR_W, 7, instruction-memory word-address width (depth = 2**ADDR_W words, matches pc[8:2]).

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; begins a load when in IDLE, DONE or ERROR
byte_valid  input  1  source has a byte on byte_data
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts byte this cycle; transfer = byte_valid & byte_ready
wr_en  output  1  instruction-memory write strobe, one cycle per word
wr_addr  output  ADDR_W  word address of write
wr_data  output  32  word to write
cpu_hold  output  1  keep CPU in reset
busy  output  1  load in progress
done  output  1  last load completed with good checksum (level)
error  output  1  last load aborted or checksum bad (level)
word_count  output  ADDR_W+1  words written in current/last load

Behaviour:
- Reset (sync, clock edge with reset=1) forces:
  - state IDLE;
  - byte_ready, wr_en, cpu_hold, busy, done, error = 0;
  - wr_addr, wr_data, word_count = 0;
  - checksum accumulator = 0.
  - Reset overrides start and any transfer in the same cycle. Reset mid-load abandons the load; words already written stay in memory.
- Frame format: LEN_HI, LEN_LO (N, 16-bit big-endian), then N words of 4 bytes each, MSB first, then 1 checksum byte. Checksum = XOR of all 4N payload bytes (length bytes excluded).
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + start: go to LEN_HI. Clear done, error, word_count, accumulator and byte index. Set cpu_hold=1, busy=1. start is ignored in every other state.
- byte_ready = 1 only in LEN_HI, LEN_LO, DATA, CHECK. It is a registered-state decode and does not depend on byte_valid.
- LEN_HI: on transfer, latch high byte and go to LEN_LO.
- LEN_LO: on transfer, form N.
  - N == 0 or N > 2**ADDR_W: go to ERROR.
  - Otherwise go to DATA, byte index 0.
- DATA: on each transfer, shift the byte into the word register (MSB first) and XOR it into the accumulator.
  - On the 4th byte, go to WRITE.
- WRITE: exactly one cycle.
  - wr_en=1; wr_addr = word_count[ADDR_W-1:0]; wr_data = assembled word; byte_ready=0.
  - Next cycle: word_count+1. Go to CHECK if word_count+1 == N, else DATA.
- Latency: 4th byte accepted at edge t. wr_en is high in cycle t+1. byte_ready returns in cycle t+2.
- CHECK: on transfer, compare byte to accumulator.
  - Equal: go to DONE, done=1.
  - Not equal: go to ERROR, error=1.
- DONE: cpu_hold=0, busy=0, done=1.
- ERROR: busy=0, error=1, cpu_hold stays 1 so a bad image never runs. Leave ERROR only by start or reset.
- wr_en is 0 outside WRITE. wr_addr/wr_data hold their last values.
- Writes never exceed address 2**ADDR_W-1, because the length is checked first.
- byte_valid may drop mid-word with no effect. State holds and partial bytes are kept.
- done and error are never both 1.

Test Plan:
1. Reset, start, stream 00 01 | 12 34 56 78 | 08 -> one wr_en with wr_addr=0, wr_data=0x12345678; then done=1, cpu_hold=0, word_count=1.
2. N=3, words 0xDEADBEEF, 0x00000001, 0xFFFFFFFF, correct checksum, byte_valid toggling every other cycle -> writes at addr 0,1,2 with those values; byte_ready low the cycle after each 4th byte; done=1.
3. Length 00 00, and separately 00 81 (ADDR_W=7) -> ERROR after LEN_LO; no wr_en; error=1, cpu_hold=1; a following start restarts cleanly.
4. N=1 word 0x11223344 with checksum 0x00 (correct is 0x44) -> word written at addr 0, then error=1, done=0, cpu_hold=1.
5. N=128, all 128 words written, last at wr_addr=127 -> done=1, word_count=128; no write to other addresses.
6. Reset asserted after 2 of 4 bytes of word 1 (in the same cycle as byte_valid and start) -> next cycle all outputs are at reset values and state is IDLE; start pulses during DATA are ignored.
